// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and
// correct/mispredict statistics; lookup is combinational on PCF.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredictedF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            update_en,
  input  logic [XLEN-1:0] PCE,
  input  logic            ActualE,
  input  logic            jumpE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            Prediction_CorrectE,
  input  logic            Eval_branchE,
  output logic [31:0]     correct_count,
  output logic [31:0]     mispredict_count
);

  localparam int N  = 1 << INDEX_BITS;
  localparam int TW = XLEN - INDEX_BITS - 2;

  logic [N-1:0]    valid_q, valid_d;
  logic [TW-1:0]   tag_q [N];
  logic [TW-1:0]   tag_d [N];
  logic [XLEN-1:0] tgt_q [N];
  logic [XLEN-1:0] tgt_d [N];
  logic [1:0]      ctr_q [N];
  logic [1:0]      ctr_d [N];
  logic [31:0]     correct_q, correct_d;
  logic [31:0]     mispred_q, mispred_d;

  logic [INDEX_BITS-1:0] f_idx, e_idx;
  logic [TW-1:0]         f_tag, e_tag;
  logic                  f_hit, e_hit;
  logic                  unused_low;

  assign f_idx = PCF[INDEX_BITS+1:2];
  assign f_tag = PCF[XLEN-1:INDEX_BITS+2];
  assign e_idx = PCE[INDEX_BITS+1:2];
  assign e_tag = PCE[XLEN-1:INDEX_BITS+2];
  assign unused_low = ^{PCF[1:0], PCE[1:0]};

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Reads the pre-update entry: no write bypass.
  assign PredictedF  = f_hit & ctr_q[f_idx][1];
  assign PredTargetF = PredictedF ? tgt_q[f_idx]
                                  : PCF + XLEN'(4);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (update_en) begin
      if (e_hit) begin
        if (jumpE) begin
          ctr_d[e_idx] = 2'b11;
          tgt_d[e_idx] = TargetE;
        end else if (ActualE) begin
          if (ctr_q[e_idx] != 2'b11)
            ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
          tgt_d[e_idx] = TargetE;
        end else begin
          if (ctr_q[e_idx] != 2'b00)
            ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
        end
      end else if (ActualE) begin
        valid_d[e_idx] = 1'b1;
        tag_d[e_idx]   = e_tag;
        tgt_d[e_idx]   = TargetE;
        ctr_d[e_idx]   = jumpE ? 2'b11 : 2'b10;
      end
    end
  end

  // Mispredict wins if both verdicts arrive together.
  always_comb begin
    correct_d = correct_q;
    mispred_d = mispred_q;
    if (Eval_branchE) begin
      if (mispred_q != 32'hFFFF_FFFF)
        mispred_d = mispred_q + 32'd1;
    end else if (Prediction_CorrectE) begin
      if (correct_q != 32'hFFFF_FFFF)
        correct_d = correct_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      correct_q <= '0;
      mispred_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      ctr_q     <= ctr_d;
      correct_q <= correct_d;
      mispred_q <= mispred_d;
    end
  end

  assign correct_count    = correct_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan
// followed by random traffic against a table-level model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF = 32'h100;
  logic        PredictedF;
  logic [31:0] PredTargetF;
  logic        update_en = 1'b0;
  logic [31:0] PCE = '0;
  logic        ActualE = 1'b0;
  logic        jumpE = 1'b0;
  logic [31:0] TargetE = '0;
  logic        Prediction_CorrectE = 1'b0;
  logic        Eval_branchE = 1'b0;
  logic [31:0] correct_count;
  logic [31:0] mispredict_count;

  branch_predictor dut (
    .clk(clk), .reset(reset),
    .PCF(PCF), .PredictedF(PredictedF),
    .PredTargetF(PredTargetF),
    .update_en(update_en), .PCE(PCE),
    .ActualE(ActualE), .jumpE(jumpE),
    .TargetE(TargetE),
    .Prediction_CorrectE(Prediction_CorrectE),
    .Eval_branchE(Eval_branchE),
    .correct_count(correct_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        p;
    logic [31:0] t;
    logic [31:0] c;
    logic [31:0] m;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;

  // Model: per-slot remembered branch with a strength 0..3.
  bit          m_v[64];
  logic [23:0] m_tag[64];
  logic [31:0] m_tgt[64];
  int          m_str[64];
  logic [31:0] m_cor, m_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic [23:0] tg(input logic [31:0] pc);
    return pc[31:8];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_str[i] = 1;
    end
    m_cor = '0;
    m_mis = '0;
  endtask

  task automatic check(input string nm, input string f,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] pcf,
                       input logic ue, input logic [31:0] pce,
                       input logic act, input logic jmp,
                       input logic [31:0] tgt,
                       input logic cor, input logic mis,
                       input string nm);
    exp_t e;
    int   s;
    bit   h;
    @(posedge clk);
    #1;
    reset = r; PCF = pcf; update_en = ue; PCE = pce;
    ActualE = act; jumpE = jmp; TargetE = tgt;
    Prediction_CorrectE = cor; Eval_branchE = mis;
    if (r) model_clear();
    s = slot(pcf);
    e.p = m_v[s] && m_tag[s] == tg(pcf) && m_str[s] >= 2;
    e.t = e.p ? m_tgt[s] : pcf + 32'd4;
    e.c = m_cor;
    e.m = m_mis;
    q.push_back(e);
    nq.push_back(nm);
    if (!r) begin
      if (ue) begin
        s = slot(pce);
        h = m_v[s] && m_tag[s] == tg(pce);
        if (h && jmp) begin
          m_str[s] = 3;
          m_tgt[s] = tgt;
        end else if (h && act) begin
          m_str[s] = (m_str[s] + 1 > 3) ? 3 : m_str[s] + 1;
          m_tgt[s] = tgt;
        end else if (h) begin
          m_str[s] = (m_str[s] - 1 < 0) ? 0 : m_str[s] - 1;
        end else if (act) begin
          m_v[s] = 1;
          m_tag[s] = tg(pce);
          m_tgt[s] = tgt;
          m_str[s] = jmp ? 3 : 2;
        end
      end
      if (mis) begin
        if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      end else if (cor) begin
        if (m_cor != 32'hFFFF_FFFF) m_cor = m_cor + 1;
      end
    end
  endtask

  task automatic br(input logic [31:0] pcf,
                    input logic [31:0] pce, input logic act,
                    input logic [31:0] tgt, input string nm);
    cycle(0, pcf, 1, pce, act, 0, tgt, 0, 0, nm);
  endtask

  task automatic look(input logic [31:0] pcf,
                      input logic cor, input logic mis,
                      input string nm);
    cycle(0, pcf, 0, 32'h40, 1, 1, 32'hDEAD, cor, mis, nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        nm = nq.pop_front();
        check(nm, "pred", {31'd0, PredictedF}, {31'd0, e.p});
        check(nm, "tgt", PredTargetF, e.t);
        check(nm, "cor", correct_count, e.c);
        check(nm, "mis", mispredict_count, e.m);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, b;
    int          k;
    model_clear();
    // Reset held across edges, with an update that must be dropped.
    cycle(1, 32'h100, 1, 32'h100, 1, 0, 32'h500, 1, 1, "rst0");
    cycle(1, 32'h100, 1, 32'h100, 1, 0, 32'h500, 1, 1, "rst1");
    look(32'h100, 0, 0, "cold");
    look(32'h100, 0, 0, "cold2");

    br(32'h40, 32'h40, 1, 32'h80, "alloc");
    br(32'h40, 32'h40, 0, 32'h0, "nt1");
    br(32'h40, 32'h40, 0, 32'h0, "nt2");
    br(32'h40, 32'h40, 0, 32'h0, "nt3");
    br(32'h40, 32'h40, 1, 32'h80, "tk1");
    br(32'h40, 32'h40, 1, 32'h80, "tk2");
    look(32'h40, 0, 0, "up");

    cycle(0, 32'h200, 1, 32'h200, 1, 1, 32'h1000, 0, 0,
          "jump");
    br(32'h200, 32'h200, 0, 32'h0, "jnt");
    look(32'h200, 0, 0, "jchk");

    br(32'h40, 32'h140, 1, 32'h900, "alias");
    look(32'h40, 0, 0, "amiss");
    br(32'h140, 32'h240, 0, 32'h0, "ant");
    look(32'h140, 0, 0, "akeep");

    br(32'h300, 32'h300, 1, 32'h3000, "rw");
    look(32'h300, 0, 0, "rw2");

    look(32'h0, 1, 0, "c1");
    look(32'h0, 1, 0, "c2");
    look(32'h0, 0, 1, "m1");
    look(32'h0, 1, 0, "c3");
    look(32'h0, 0, 1, "m2");
    look(32'h0, 1, 1, "both");
    look(32'h0, 0, 0, "stat");

    // Reset asserted between edges with an update pending.
    cycle(1, 32'h300, 1, 32'h300, 1, 0, 32'h7, 1, 0, "arst");
    look(32'h300, 0, 0, "post");
    look(32'h40, 1, 0, "post2");

    @(negedge clk);
    #2;
    force dut.correct_q = 32'hFFFF_FFFF;
    m_cor = 32'hFFFF_FFFF;
    look(32'h0, 0, 0, "forced");
    release dut.correct_q;
    look(32'h0, 1, 0, "sat1");
    look(32'h0, 1, 0, "sat2");
    look(32'h0, 0, 0, "sat3");

    for (int i = 0; i < 3000; i++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 6'd0, 2'd0};
      a[7:2] = 6'($urandom_range(0, 7));
      a[1:0] = 2'($urandom);
      b = {22'd0, 2'($urandom_range(0, 3)), 6'd0, 2'd0};
      b[7:2] = 6'($urandom_range(0, 7));
      k = $urandom_range(0, 99);
      if (k < 2)
        cycle(1, a, 1, b, 1, 0, $urandom, 0, 0, "rrst");
      else if (k < 12)
        cycle(0, a, 1, b, 1, 1, $urandom, 0, 1, "rjmp");
      else if (k < 70)
        cycle(0, a, 1, b, 1'($urandom), 0, $urandom,
              1'($urandom), 1'($urandom_range(0, 3) == 0),
              "rbr");
      else
        cycle(0, a, 0, b, 1'($urandom), 1'($urandom),
              $urandom, 1'($urandom), 1'($urandom),
              "ridle");
    end

    @(negedge clk);
    #1;
    check("drain", "qsize", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
